// File: rtl/tri_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : tri_bus_arbiter_if
// Brief     : Request/grant handshake bundle between local datapath masters
//             and the shared tri-state bus arbiter. The bidirectional bus
//             itself stays a plain inout net on the arbiter.
// Revision  : 1.0 - initial release
// ============================================================================
interface tri_bus_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] din;
    logic [N-1:0]       gnt;
    logic               oe;
    logic [WIDTH-1:0]   bus_rd;
    logic               busy;
    logic               err;

    // Requesters drive req/din and observe grant and status.
    modport master (
        output req,
        output din,
        input  gnt,
        input  oe,
        input  bus_rd,
        input  busy,
        input  err
    );

    // The arbiter consumes requests and produces grant and status.
    modport slave (
        input  req,
        input  din,
        output gnt,
        output oe,
        output bus_rd,
        output busy,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/tri_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tri_bus_arbiter
// Brief    : Round-robin owner selection for a shared tri-state bus. Grant and
//            output enable are registered; TURN dead cycles separate owners.
// Options  : TRI_BUS_CONTENTION_CHK_EN - sticky contention flag on err.
//            Undefined: err is tied low and no checker is built.
// Revision : 1.0 - initial release
// ============================================================================
module tri_bus_arbiter #(
    parameter int WIDTH    = 8,
    parameter int N        = 4,
    parameter int TURN     = 1,
    parameter int MAX_HOLD = 16
) (
    input  wire              clk,
    input  wire              rst_n,
    tri_bus_arbiter_if.slave bif,
    inout  wire [WIDTH-1:0]  bus
);
    localparam int c_idx_w  = (N > 1) ? $clog2(N) : 1;
    localparam int c_hold_w = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int c_turn_w = (TURN > 1) ? $clog2(TURN) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(MAX_HOLD - 1);
    localparam logic [c_turn_w-1:0] c_turn_last = c_turn_w'(TURN - 1);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [c_idx_w-1:0]    ptr_q, ptr_d;
    logic [c_idx_w-1:0]    owner_q, owner_d;
    logic [c_hold_w-1:0]   hold_cnt_q, hold_cnt_d;
    logic [c_turn_w-1:0]   turn_cnt_q, turn_cnt_d;
    logic [N-1:0]          gnt_q, gnt_d;
    logic                  oe_q, oe_d;
    logic [WIDTH-1:0]      bus_rd_q, bus_rd_d;

    logic                  pick_found;
    logic [c_idx_w-1:0]    pick_idx;
    logic [c_idx_w-1:0]    pick_next;
    logic [WIDTH-1:0]      drive_data;

    // Round-robin scan from ptr upward with wrap; the closest set request wins.
    always_comb begin
        int j;
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (bif.req[c_idx_w'(j)]) begin
                pick_found = 1'b1;
                pick_idx   = c_idx_w'(j);
            end
        end
        pick_next = (pick_idx == c_idx_last) ? '0 : pick_idx + c_idx_w'(1);
    end

    // Owner data goes straight onto the bus; only the enable is registered.
    always_comb begin
        drive_data = bif.din[owner_q*WIDTH +: WIDTH];
    end

    assign bus = oe_q ? drive_data : {WIDTH{1'bz}};

    // Next-state and registered-output logic for IDLE / DRIVE / TURN.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        gnt_d      = gnt_q;
        oe_d       = oe_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d         = ST_DRIVE;
                    owner_d         = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    oe_d            = 1'b1;
                    ptr_d           = pick_next;
                    hold_cnt_d      = '0;
                end
            end
            ST_DRIVE: begin
                // Release and hold-limit landing together still give one exit.
                if (!bif.req[owner_q] || (hold_cnt_q == c_hold_last)) begin
                    state_d    = ST_TURN;
                    gnt_d      = '0;
                    oe_d       = 1'b0;
                    turn_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + c_hold_w'(1);
                end
            end
            ST_TURN: begin
                gnt_d = '0;
                oe_d  = 1'b0;
                if (turn_cnt_q == c_turn_last) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q + c_turn_w'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                oe_d    = 1'b0;
            end
        endcase
    end

    // The read capture follows the bus only while this block is not driving.
    always_comb begin
        bus_rd_d = oe_q ? bus_rd_q : bus;
    end

    // State register; async reset drops the enable immediately, even mid-drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            gnt_q      <= '0;
            oe_q       <= 1'b0;
            bus_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            gnt_q      <= gnt_d;
            oe_q       <= oe_d;
            bus_rd_q   <= bus_rd_d;
        end
    end

    assign bif.gnt    = gnt_q;
    assign bif.oe     = oe_q;
    assign bif.bus_rd = bus_rd_q;
    assign bif.busy   = (state_q != ST_IDLE);

`ifdef TRI_BUS_CONTENTION_CHK_EN
    logic err_q, err_d;

    // Any resolved-bus disagreement with the owner data (X/Z included) sets err.
    always_comb begin
        err_d = err_q;
        if (oe_q) begin
            if (bus == drive_data) begin
                err_d = err_q;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Sticky contention flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bif.err = err_q;
`else
    assign bif.err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tri_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tri_bus_arbiter
// Brief    : Self-checking bench for tri_bus_arbiter: directed scenarios plus
//            randomized request traffic against a behavioural owner model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tri_bus_arbiter;
    localparam int WIDTH    = 8;
    localparam int N        = 4;
    localparam int TURN     = 1;
    localparam int MAX_HOLD = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] ext_val = '0;
    logic             ext_force = 1'b0;
    wire  [WIDTH-1:0] bus;

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural model: who owns the bus, for how many cycles, dead cycles left.
    int               m_owner;
    int               m_held;
    int               m_dead;
    int               m_ptr;
    logic [WIDTH-1:0] m_bus_rd;

    tri_bus_arbiter_if #(.WIDTH(WIDTH), .N(N)) bif ();

    tri_bus_arbiter #(
        .WIDTH    (WIDTH),
        .N        (N),
        .TURN     (TURN),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif),
        .bus   (bus)
    );

    // Board-side device: drives the bus whenever the arbiter is not enabled.
    assign bus = (!bif.oe || ext_force) ? ext_val : {WIDTH{1'bz}};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_held   = 0;
        m_dead   = 0;
        m_ptr    = 0;
        m_bus_rd = '0;
    endtask

    // One rising edge of the reference, using the inputs present before the edge.
    task automatic model_step();
        if (m_owner < 0) begin
            m_bus_rd = ext_val;
        end
        if (m_owner >= 0) begin
            if (((32'(bif.req) >> m_owner) & 32'd1) == 32'd0 || m_held == MAX_HOLD) begin
                m_owner = -1;
                m_dead  = TURN;
            end else begin
                m_held++;
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (((32'(bif.req) >> c) & 32'd1) != 32'd0) begin
                    m_owner = c;
                    m_held  = 1;
                    m_ptr   = (c + 1) % N;
                    break;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        logic [N-1:0]     exp_gnt;
        logic [WIDTH-1:0] exp_bus;
        exp_gnt = '0;
        exp_bus = ext_val;
        if (m_owner >= 0) begin
            exp_gnt = N'(1) << m_owner;
            exp_bus = bif.din[m_owner*WIDTH +: WIDTH];
        end
        chk({ph, ".gnt"},    32'(bif.gnt),    32'(exp_gnt));
        chk({ph, ".oe"},     32'(bif.oe),     32'(m_owner >= 0));
        chk({ph, ".busy"},   32'(bif.busy),   32'((m_owner >= 0) || (m_dead > 0)));
        chk({ph, ".bus_rd"}, 32'(bif.bus_rd), 32'(m_bus_rd));
        chk({ph, ".err"},    32'(bif.err),    32'd0);
        chk({ph, ".bus"},    32'(bus),        32'(exp_bus));
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        model_step();
        #1;
        check_all(ph);
    endtask

    task automatic set_slice(input int ch, input logic [WIDTH-1:0] val);
        logic [N*WIDTH-1:0] d;
        d = bif.din;
        d[ch*WIDTH +: WIDTH] = val;
        bif.din = d;
    endtask

    initial begin
        int cnt;
        int guard;
        int run_len;
        int q_own[$];
        int q_len[$];
        logic [N-1:0] prev_gnt;

        model_reset();
        bif.req = '0;
        bif.din = {$urandom, $urandom};
        ext_val = WIDTH'($urandom);

        // T1: reset held with every channel requesting.
        bif.req = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check_all("t1_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick("t1");
        chk("t1_first_gnt", 32'(bif.gnt), 32'b0001);

        // Drain back to idle.
        bif.req = '0;
        repeat (4) tick("drain1");

        // T2: single owner for five cycles, then one dead cycle.
        bif.req = 4'b0100;
        set_slice(2, 8'hA5);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick("t2");
            if (bif.gnt == 4'b0100) cnt++;
            chk("t2_bus", 32'(bus), 32'h000000A5);
        end
        bif.req = '0;
        tick("t2_rel");
        chk("t2_turn_busy", 32'(bif.busy), 32'd1);
        tick("t2_idle");
        chk("t2_busy_fall", 32'(bif.busy), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick("t2_tail");
            if (bif.gnt == 4'b0100) cnt++;
        end
        chk("t2_len", 32'(cnt), 32'd5);

        // T5: reset in the middle of a drive phase.
        bif.req = 4'b0010;
        set_slice(1, 8'h3C);
        repeat (3) tick("t5");
        chk("t5_bus_pre", 32'(bus), 32'h0000003C);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_oe",   32'(bif.oe),   32'd0);
        chk("t5_gnt",  32'(bif.gnt),  32'd0);
        chk("t5_busy", 32'(bif.busy), 32'd0);
        chk("t5_bus",  32'(bus),      32'(ext_val));
        @(negedge clk);
        rst_n   = 1'b1;
        bif.req = 4'b1111;

        // T3: all channels requesting; order from a zeroed pointer.
        prev_gnt = '0;
        run_len  = 0;
        for (int i = 0; i < 80; i++) begin
            tick("t3");
            if (bif.gnt != '0) begin
                if (prev_gnt == '0) begin
                    for (int c = 0; c < N; c++) if (bif.gnt[c]) q_own.push_back(c);
                end
                run_len++;
            end else if (prev_gnt != '0) begin
                q_len.push_back(run_len);
                run_len = 0;
            end
            prev_gnt = bif.gnt;
            bif.din  = {$urandom, $urandom};
        end
        chk("t3_grants", 32'(q_own.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < q_own.size(); i++) begin
            chk($sformatf("t3_order%0d", i), 32'(q_own[i]), 32'(i % N));
        end
        chk("t3_runs", 32'(q_len.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < q_len.size(); i++) begin
            chk($sformatf("t3_len%0d", i), 32'(q_len[i]), 32'(MAX_HOLD));
        end

        // T4: owner drops its request on the same edge the hold limit hits.
        bif.req = 4'b0010;
        guard = 0;
        while (bif.gnt != 4'b0010 && guard < 60) begin
            tick("t4_wait");
            guard++;
        end
        chk("t4_owned", 32'(bif.gnt), 32'b0010);
        repeat (MAX_HOLD - 1) tick("t4_hold");
        chk("t4_still_owned", 32'(bif.gnt), 32'b0010);
        bif.req = '0;
        tick("t4_exit");
        chk("t4_exit_gnt",  32'(bif.gnt),  32'd0);
        chk("t4_exit_busy", 32'(bif.busy), 32'd1);
        tick("t4_idle");
        chk("t4_idle_busy", 32'(bif.busy), 32'd0);
        tick("t4_quiet");
        chk("t4_no_regrant", 32'(bif.gnt), 32'd0);

        // Randomized traffic: requests toggle occasionally, data and board value churn.
        for (int i = 0; i < 600; i++) begin
            tick("rand");
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 5) == 0) bif.req[c] = ~bif.req[c];
            end
            bif.din = {$urandom, $urandom};
            ext_val = WIDTH'($urandom);
        end

`ifdef TRI_BUS_CONTENTION_CHK_EN
        // T6: external driver fights the owner; err must set and stick.
        bif.req = 4'b0001;
        guard = 0;
        while (bif.gnt != 4'b0001 && guard < 60) begin
            tick("t6_wait");
            set_slice(0, 8'h00);
            guard++;
        end
        set_slice(0, 8'h00);
        chk("t6_owned", 32'(bif.gnt), 32'b0001);
        ext_val   = 8'hFF;
        ext_force = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_err_set", 32'(bif.err), 32'd1);
        ext_force = 1'b0;
        bif.req   = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_err_sticky", 32'(bif.err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_err_clr", 32'(bif.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
